// File: rtl/oled_text_scheduler.sv
// oled_text_scheduler
// Owns a NUM_ASCII_COL x NUM_ASCII_ROW character framebuffer and drives the
// OLED interface command port. Content changes trigger a fill_screen
// (after a clear) and/or a pixel_display command, spaced by MIN_GAP_TICKS.
//
// Ports:
//   i_CLK, i_RST_N          clock, synchronous active-low reset
//   i_WR_EN/COL/ROW/CHAR    random-access character write
//   i_CLEAR                 clear-screen pulse (wins over a same-cycle write)
//   i_TEXT_COLOR            text colour, sampled when a command is issued
//   i_BACKGROUND_COLOR      background colour, sampled when a command is issued
//   i_OLED_READY            interface ready (asynchronous, synchronised here)
//   o_MODE                  01 = fill_screen, 10 = pixel_display
//   o_START                 level request, held until the interface accepts
//   o_ASCII                 framebuffer snapshot, row 0 col 0 in the MSB byte
//   o_TEXT_COLOR            colour captured at issue
//   o_BACKGROUND_COLOR      colour captured at issue
//   o_BUSY                  high whenever the sequencer is not idle
//   o_FRAME_DONE            1-cycle pulse when a pixel_display completes
//   o_WR_ERR                1-cycle pulse on an out-of-range write
//   o_TIMEOUT               1-cycle pulse on accept timeout
//
// Optional feature macro: OLED_SCHED_TIMEOUT_EN (accept timeout with retry).
module oled_text_scheduler #(
    parameter int unsigned NUM_ASCII_COL = 12,
    parameter int unsigned NUM_ASCII_ROW = 8,
    parameter int unsigned N_COLOR_BITS  = 8,
    parameter int unsigned MIN_GAP_TICKS = 500000,
    parameter int unsigned TIMEOUT_TICKS = 1000000
) (
    input  logic                                   i_CLK,
    input  logic                                   i_RST_N,
    input  logic                                   i_WR_EN,
    input  logic [3:0]                             i_WR_COL,
    input  logic [2:0]                             i_WR_ROW,
    input  logic [7:0]                             i_WR_CHAR,
    input  logic                                   i_CLEAR,
    input  logic [N_COLOR_BITS-1:0]                i_TEXT_COLOR,
    input  logic [N_COLOR_BITS-1:0]                i_BACKGROUND_COLOR,
    input  logic                                   i_OLED_READY,
    output logic [1:0]                             o_MODE,
    output logic                                   o_START,
    output logic [NUM_ASCII_COL*NUM_ASCII_ROW*8-1:0] o_ASCII,
    output logic [N_COLOR_BITS-1:0]                o_TEXT_COLOR,
    output logic [N_COLOR_BITS-1:0]                o_BACKGROUND_COLOR,
    output logic                                   o_BUSY,
    output logic                                   o_FRAME_DONE,
    output logic                                   o_WR_ERR,
    output logic                                   o_TIMEOUT
);

    localparam int unsigned CELLS  = NUM_ASCII_COL * NUM_ASCII_ROW;
    localparam int unsigned TOTAL  = CELLS * 8;
    localparam int unsigned CELL_W = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int unsigned GAP_W  = (MIN_GAP_TICKS > 1) ? $clog2(MIN_GAP_TICKS) : 1;

    localparam logic [1:0] MODE_FILL = 2'b01;
    localparam logic [1:0] MODE_PIX  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    // READY synchroniser
    logic rdy_meta;
    logic rdy_s;

    always_ff @(posedge i_CLK) begin
        if (!i_RST_N) begin
            rdy_meta <= 1'b0;
            rdy_s    <= 1'b0;
        end else begin
            rdy_meta <= i_OLED_READY;
            rdy_s    <= rdy_meta;
        end
    end

    // Write decode; a clear in the same cycle drops the write entirely
    logic              wr_in_range;
    logic              wr_ok;
    logic              wr_bad;
    logic [CELL_W-1:0] wr_idx;

    assign wr_in_range = (32'(i_WR_COL) < NUM_ASCII_COL) && (32'(i_WR_ROW) < NUM_ASCII_ROW);
    assign wr_ok       = i_WR_EN && !i_CLEAR && wr_in_range;
    assign wr_bad      = i_WR_EN && !i_CLEAR && !wr_in_range;
    assign wr_idx      = CELL_W'(i_WR_ROW) * CELL_W'(NUM_ASCII_COL) + CELL_W'(i_WR_COL);

    // Framebuffer storage, cell index = row*NUM_ASCII_COL + col
    logic [7:0] fb [CELLS];
    logic       wr_err_q;

    always_ff @(posedge i_CLK) begin
        if (!i_RST_N) begin
            for (int unsigned k = 0; k < CELLS; k++) fb[k] <= 8'h20;
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_bad;
            if (i_CLEAR) begin
                for (int unsigned k = 0; k < CELLS; k++) fb[k] <= 8'h20;
            end else if (wr_ok) begin
                fb[wr_idx] <= i_WR_CHAR;
            end
        end
    end

    // Flatten so cell 0 lands in the most significant byte
    logic [TOTAL-1:0] fb_flat;

    always_comb begin
        fb_flat = '0;
        for (int unsigned k = 0; k < CELLS; k++) begin
            fb_flat[TOTAL-1-8*k -: 8] = fb[k];
        end
    end

    // Sequencer registers
    state_t                  state,      state_d;
    logic [1:0]              mode_q,     mode_d;
    logic                    start_q,    start_d;
    logic [N_COLOR_BITS-1:0] txt_q,      txt_d;
    logic [N_COLOR_BITS-1:0] bg_q,       bg_d;
    logic                    busy_q,     busy_d;
    logic                    fdone_q,    fdone_d;
    logic [GAP_W-1:0]        gap_cnt,    gap_d;
    logic                    dirty,      dirty_d;
    logic                    clr_pend,   clr_d;
    logic                    rdy_seen,   seen_d;
    logic [TOTAL-1:0]        snap_q,     snap_d;
    logic                    accept;
`ifdef OLED_SCHED_TIMEOUT_EN
    logic [31:0]             to_cnt,     to_d;
    logic                    timeout_q,  timeout_d;
`endif

    // Accept only counts once READY has been seen high (interface power-on done)
    assign accept = rdy_seen && !rdy_s;

    always_ff @(posedge i_CLK) begin
        if (!i_RST_N) begin
            state     <= S_IDLE;
            mode_q    <= '0;
            start_q   <= 1'b0;
            txt_q     <= '0;
            bg_q      <= '0;
            busy_q    <= 1'b0;
            fdone_q   <= 1'b0;
            gap_cnt   <= '0;
            dirty     <= 1'b0;
            clr_pend  <= 1'b0;
            rdy_seen  <= 1'b0;
            snap_q    <= {CELLS{8'h20}};
`ifdef OLED_SCHED_TIMEOUT_EN
            to_cnt    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state     <= state_d;
            mode_q    <= mode_d;
            start_q   <= start_d;
            txt_q     <= txt_d;
            bg_q      <= bg_d;
            busy_q    <= busy_d;
            fdone_q   <= fdone_d;
            gap_cnt   <= gap_d;
            dirty     <= dirty_d;
            clr_pend  <= clr_d;
            rdy_seen  <= seen_d;
            snap_q    <= snap_d;
`ifdef OLED_SCHED_TIMEOUT_EN
            to_cnt    <= to_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d = state;
        mode_d  = mode_q;
        start_d = start_q;
        txt_d   = txt_q;
        bg_d    = bg_q;
        fdone_d = 1'b0;
        gap_d   = gap_cnt;
        dirty_d = dirty;
        clr_d   = clr_pend;
        seen_d  = rdy_seen | rdy_s;
        snap_d  = snap_q;
`ifdef OLED_SCHED_TIMEOUT_EN
        to_d      = '0;
        timeout_d = 1'b0;
`endif

        case (state)
            S_IDLE: begin
                if (clr_pend) begin
                    mode_d  = MODE_FILL;
                    txt_d   = i_TEXT_COLOR;
                    bg_d    = i_BACKGROUND_COLOR;
                    clr_d   = 1'b0;
                    start_d = 1'b1;
                    state_d = S_ISSUE;
                end else if (dirty) begin
                    snap_d  = fb_flat;
                    mode_d  = MODE_PIX;
                    txt_d   = i_TEXT_COLOR;
                    bg_d    = i_BACKGROUND_COLOR;
                    dirty_d = 1'b0;
                    start_d = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (accept) begin
                    start_d = 1'b0;
                    state_d = S_WAIT_DONE;
                end
`ifdef OLED_SCHED_TIMEOUT_EN
                else if (to_cnt == 32'(TIMEOUT_TICKS - 1)) begin
                    // Abort and re-arm the request so it is retried after the gap
                    start_d   = 1'b0;
                    timeout_d = 1'b1;
                    gap_d     = '0;
                    state_d   = S_GAP;
                    if (mode_q == MODE_FILL) clr_d = 1'b1;
                    else                     dirty_d = 1'b1;
                end else begin
                    to_d = to_cnt + 32'd1;
                end
`endif
            end
            S_WAIT_DONE: begin
                if (rdy_s) begin
                    gap_d   = '0;
                    fdone_d = (mode_q == MODE_PIX);
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_W'(MIN_GAP_TICKS - 1)) state_d = S_IDLE;
                else                                      gap_d = gap_cnt + GAP_W'(1);
            end
            default: state_d = S_IDLE;
        endcase

        // New content always re-arms, even in the cycle a request is consumed
        if (i_CLEAR) begin
            clr_d   = 1'b1;
            dirty_d = 1'b1;
        end else if (wr_ok) begin
            dirty_d = 1'b1;
        end

        busy_d = (state_d != S_IDLE);
    end

    assign o_MODE             = mode_q;
    assign o_START            = start_q;
    assign o_ASCII            = snap_q;
    assign o_TEXT_COLOR       = txt_q;
    assign o_BACKGROUND_COLOR = bg_q;
    assign o_BUSY             = busy_q;
    assign o_FRAME_DONE       = fdone_q;
    assign o_WR_ERR           = wr_err_q;

`ifdef OLED_SCHED_TIMEOUT_EN
    assign o_TIMEOUT = timeout_q;
`else
    logic unused_timeout_param;
    assign unused_timeout_param = (TIMEOUT_TICKS == 0);
    assign o_TIMEOUT = 1'b0;
`endif

endmodule
